// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit for the 16-bit MIPS core.
// Tracks destination tags through ID/EX, EX/MEM and MEM/WB and counts stall cycles.

module fwd_sel_lane (
    input  logic [2:0] src,
    input  logic       exm_wr,
    input  logic [2:0] exm_dst,
    input  logic       mwb_wr,
    input  logic [2:0] mwb_dst,
    output logic [1:0] sel
);
    // Newest producer (EX/MEM) wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        sel = 2'b00;
        if (src != 3'd0 && exm_wr && exm_dst == src)
            sel = 2'b01;
        else if (src != 3'd0 && mwb_wr && mwb_dst == src)
            sel = 2'b10;
    end
endmodule

module fwd_hazard_unit #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [2:0]             id_rs,
    input  logic [2:0]             id_rt,
    input  logic [2:0]             id_dst,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int NUM_LANES = 2;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] dst;
        logic       reg_write;
        logic       mem_read;
    } idex_t;

    typedef struct packed {
        logic [2:0] dst;
        logic       reg_write;
    } wtag_t;

    // vld_pipe[0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB
    logic [2:0] vld_pipe;
    idex_t      idex;
    wtag_t      exm;
    wtag_t      mwb;
    logic       id_take;
    logic       ex_load;
    logic       hit_rs;
    logic       hit_rt;

    logic [NUM_LANES-1:0][2:0] lane_src;
    logic [NUM_LANES-1:0][1:0] lane_sel;

    assign lane_src = {idex.rt, idex.rs};

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            fwd_sel_lane u_lane (
                .src     (lane_src[i]),
                .exm_wr  (vld_pipe[1] & exm.reg_write),
                .exm_dst (exm.dst),
                .mwb_wr  (vld_pipe[2] & mwb.reg_write),
                .mwb_dst (mwb.dst),
                .sel     (lane_sel[i])
            );
        end
    endgenerate

    assign fwd_a_sel = lane_sel[0];
    assign fwd_b_sel = lane_sel[1];

    // Stall only on a load sitting in EX; a load in MEM is covered by MEM/WB forwarding.
    always_comb begin
        ex_load = vld_pipe[0] & idex.mem_read & idex.reg_write;
        hit_rs  = (id_rs != 3'd0) && (idex.dst == id_rs);
        hit_rt  = (id_rt != 3'd0) && (idex.dst == id_rt);
        stall   = ~reset & id_valid & ~flush & ex_load & (hit_rs | hit_rt);
        id_take = id_valid & ~flush & ~stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            idex      <= '0;
            exm       <= '0;
            mwb       <= '0;
            stall_cnt <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], id_take};
            if (id_take)
                idex <= '{rs: id_rs, rt: id_rt, dst: id_dst,
                          reg_write: id_reg_write, mem_read: id_mem_read};
            else
                idex <= '0;
            exm <= '{dst: idex.dst, reg_write: idex.reg_write};
            mwb <= exm;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit: forwarding selects, load-use stalls,
// flush, r0 exclusion, counter saturation and reset behaviour.

module tb_fwd_hazard_unit;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [2:0]    id_rs, id_rt, id_dst;
    logic          id_reg_write, id_mem_read, flush;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(.STALL_CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] rs, rt, dst;
        logic       rw, mr, fl;
        logic [1:0] ea, eb;
        logic       es;
        int         ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [2:0] rs, logic [2:0] rt, logic [2:0] dst,
                                logic rw, logic mr, logic fl,
                                logic [1:0] ea, logic [1:0] eb, logic es, int ec);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.dst = dst; t.rw = rw; t.mr = mr; t.fl = fl;
        t.ea = ea; t.eb = eb; t.es = es; t.ec = ec;
        return t;
    endfunction

    function automatic vec_t nop(logic [1:0] ea, logic [1:0] eb, int ec);
        return mk(0, 0, 0, 0, 0, 0, 0, ea, eb, 0, ec);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, logic [2:0] rs, logic [2:0] rt, logic [2:0] dst,
                         logic rw, logic mr, logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
        id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;

    initial begin
        // cycle-by-cycle program; each row is what ID holds that cycle
        tbl.push_back(mk(1,1,2,3,1,0,0, 0,0,0,0));   // 0  add r3<-r1,r2
        tbl.push_back(mk(1,3,3,4,1,0,0, 0,0,0,0));   // 1  sub r4<-r3,r3
        tbl.push_back(nop(1,1,0));                   // 2  sub in EX: both from EX/MEM
        tbl.push_back(nop(0,0,0));
        tbl.push_back(nop(0,0,0));
        tbl.push_back(mk(1,1,2,3,1,0,0, 0,0,0,0));   // 5  r3 producer 1
        tbl.push_back(mk(1,1,1,3,1,0,0, 0,0,0,0));   // 6  r3 producer 2
        tbl.push_back(mk(1,3,1,5,1,0,0, 0,0,0,0));   // 7  consumer of r3
        tbl.push_back(nop(1,0,0));                   // 8  newest wins
        tbl.push_back(mk(1,1,1,2,1,0,0, 0,0,0,0));   // 9  r2 producer
        tbl.push_back(mk(1,1,1,6,1,0,0, 0,0,0,0));   // 10 unrelated
        tbl.push_back(mk(1,1,2,4,1,0,0, 0,0,0,0));   // 11 consumer of r2 on B
        tbl.push_back(nop(0,2,0));                   // 12 MEM/WB forward
        tbl.push_back(nop(0,0,0));
        tbl.push_back(nop(0,0,0));
        tbl.push_back(mk(1,1,0,0,1,1,0, 0,0,0,0));   // 15 lw r0
        tbl.push_back(mk(1,0,0,1,1,0,0, 0,0,0,0));   // 16 reads r0: no stall
        tbl.push_back(nop(0,0,0));                   // 17 no forward of r0
        tbl.push_back(nop(0,0,0));
        tbl.push_back(nop(0,0,0));
        tbl.push_back(mk(1,1,5,5,1,1,0, 0,0,0,0));   // 20 lw r5
        tbl.push_back(mk(1,5,1,6,1,0,0, 0,0,1,0));   // 21 add r6<-r5,r1 stalls
        tbl.push_back(mk(1,5,1,6,1,0,0, 0,0,0,1));   // 22 held add proceeds
        tbl.push_back(nop(2,0,1));                   // 23 add in EX: MEM/WB
        tbl.push_back(nop(0,0,1));
        tbl.push_back(mk(1,1,5,5,1,1,0, 0,0,0,1));   // 25 lw r5
        tbl.push_back(mk(1,5,1,6,1,0,1, 0,0,0,1));   // 26 dependent + flush
        tbl.push_back(nop(0,0,1));                   // 27 bubble in EX
        tbl.push_back(nop(0,0,1));
        tbl.push_back(mk(1,1,5,5,1,1,0, 0,0,0,1));   // 29 lw r5
        tbl.push_back(mk(1,5,5,5,1,1,0, 0,0,1,1));   // 30 lw r5,(r5) stalls
        tbl.push_back(mk(1,5,5,5,1,1,0, 0,0,0,2));   // 31 held, once only
        tbl.push_back(mk(1,5,1,6,1,0,0, 2,2,1,2));   // 32 consumer stalls
        tbl.push_back(mk(1,5,1,6,1,0,0, 0,0,0,3));   // 33 held
        tbl.push_back(nop(2,0,3));
        tbl.push_back(nop(0,0,3));
        tbl.push_back(mk(1,1,2,2,1,1,0, 0,0,0,3));   // 36 lw r2
        tbl.push_back(mk(0,2,2,3,1,0,0, 0,0,0,3));   // 37 invalid reader: no stall
        tbl.push_back(nop(0,0,3));
        tbl.push_back(mk(1,1,4,4,1,1,0, 0,0,0,3));   // 39 lw r4
        tbl.push_back(mk(1,1,4,6,1,0,0, 0,0,1,3));   // 40 rt hit stalls
        tbl.push_back(mk(1,1,4,6,1,0,0, 0,0,0,4));   // 41
        tbl.push_back(nop(0,2,4));
        tbl.push_back(nop(0,0,4));

        // reset with random ID inputs
        reset = 1'b1;
        drive(1'b1, 3'($urandom), 3'($urandom), 3'($urandom), 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'($urandom), 3'($urandom), 3'($urandom), 1'b1, 1'b1, 1'b0);
        tick();
        chk("rst_a_sel", fwd_a_sel, 0);
        chk("rst_b_sel", fwd_b_sel, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", stall_cnt, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_cnt", stall_cnt, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].rw, tbl[i].mr, tbl[i].fl);
            #1;
            chk($sformatf("v%0d_a_sel", i), fwd_a_sel, tbl[i].ea);
            chk($sformatf("v%0d_b_sel", i), fwd_b_sel, tbl[i].eb);
            chk($sformatf("v%0d_stall", i), stall, tbl[i].es);
            chk($sformatf("v%0d_cnt", i), stall_cnt, tbl[i].ec);
            tick();
        end

        // 20 load-use pairs drive the 4-bit counter into saturation
        exp_cnt = 4;
        for (int p = 0; p < 20; p++) begin
            drive(1, 1, 5, 5, 1, 1, 0);
            #1;
            chk($sformatf("sat%0d_lw_stall", p), stall, 0);
            tick();
            drive(1, 5, 1, 6, 1, 0, 0);
            #1;
            chk($sformatf("sat%0d_stall", p), stall, 1);
            tick();
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            #1;
            chk($sformatf("sat%0d_held", p), stall, 0);
            chk($sformatf("sat%0d_cnt", p), stall_cnt, exp_cnt);
            tick();
        end
        chk("sat_final", stall_cnt, 15);

        // reset asserted during a stall: no count, hazard gone after the edge
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 5, 5, 1, 1, 0);
        tick();
        drive(1, 5, 1, 6, 1, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_cnt", stall_cnt, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_mid_a_sel", fwd_a_sel, 0);
        chk("rst_mid_cnt2", stall_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
